// File: rtl/mult_share_pkg.sv
// Shared state encoding and default parameters for the multiplier-sharing controller.
package mult_share_pkg;
  localparam int DEF_W       = 16;
  localparam int DEF_MUL_LAT = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;
endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request, multiplier-control and response signals between two requesters, the
// shared multiplier datapath and the controller.
interface mult_share_ctrl_if import mult_share_pkg::*; #(
  parameter int W = DEF_W
);
  logic           req0_valid;
  logic           req1_valid;
  logic           mul_sel;
  logic           mul_start;
  logic [2*W-1:0] mul_p;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [2*W-1:0] rsp_p;
  logic           busy;

  modport master (
    output req0_valid, req1_valid, mul_p, rsp0_ready, rsp1_ready,
    input  mul_sel, mul_start, rsp0_valid, rsp1_valid, rsp_p, busy
  );

  modport slave (
    input  req0_valid, req1_valid, mul_p, rsp0_ready, rsp1_ready,
    output mul_sel, mul_start, rsp0_valid, rsp1_valid, rsp_p, busy
  );
endinterface

// File: rtl/mult_share_ctrl_rr_arb2.sv
// Two-input round-robin picker: the pointer names the winner only when both request.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_upd,
  output logic       o_gnt_idx,
  output logic       o_any
);
  always_comb begin
    o_any     = i_upd && (|i_req);
    o_gnt_idx = 1'b0;
    if (i_req == 2'b11) begin
      o_gnt_idx = i_ptr;
    end else if (i_req[1]) begin
      o_gnt_idx = 1'b1;
    end
  end
endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one multiplier between two requesters: grant, start, wait the fixed
// latency, capture the product and hand it back over a valid/ready response.
module mult_share_ctrl import mult_share_pkg::*; #(
  parameter int W       = DEF_W,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_share_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT == 0) ? '0 : CNT_W'(MUL_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_sel;
  logic             r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_rsp_p;

  logic w_any;
  logic w_gnt_idx;
  logic w_req_gnt;
  logic w_rdy_gnt;
  logic w_take;
  logic w_load;
  logic w_capture;
  logic w_flip;

  rr_arb2 u_arb (
    .i_req     ({bus.req1_valid, bus.req0_valid}),
    .i_ptr     (r_ptr),
    .i_upd     (r_state == IDLE),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // A granted requester dropping its request before the handshake aborts the operation.
  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_flip    = 1'b0;
    w_req_gnt = r_sel ? bus.req1_valid : bus.req0_valid;
    w_rdy_gnt = r_sel ? bus.rsp1_ready : bus.rsp0_ready;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!w_req_gnt) begin
          w_flip = 1'b1;
          w_next = IDLE;
        end else if (MUL_LAT == 0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else begin
          w_load = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (!w_req_gnt) begin
          w_flip = 1'b1;
          w_next = IDLE;
        end else if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (!w_req_gnt || w_rdy_gnt) begin
          w_flip = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_rsp_p <= '0;
    end else begin
      r_state <= w_next;
      if (w_take)    r_sel <= w_gnt_idx;
      if (w_flip)    r_ptr <= ~r_sel;
      if (w_load) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) r_rsp_p <= bus.mul_p;
    end
  end

  assign bus.mul_sel    = r_sel;
  assign bus.mul_start  = (r_state == ISSUE);
  assign bus.rsp0_valid = (r_state == RESP) && !r_sel;
  assign bus.rsp1_valid = (r_state == RESP) && r_sel;
  assign bus.rsp_p      = r_rsp_p;
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: multiplier stub, per-requester expected-product queues,
// a monitor checking grants, latency and responses, and directed plus random stimulus.
module tb_mult_share_ctrl;
  localparam int W       = 16;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.W(W)) bus ();

  mult_share_ctrl #(.W(W), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Multiplier stub: product of the currently selected operands, valid only MUL_LAT cycles after start.
  logic [W-1:0] op_a [2];
  logic [W-1:0] op_b [2];
  logic st1, st2;
  always @(posedge clk) begin
    st1 <= bus.mul_start;
    st2 <= st1;
  end
  always_comb begin
    bus.mul_p = 32'hDEAD_BEEF;
    if (st2) bus.mul_p = {{W{1'b0}}, op_a[bus.mul_sel]} * {{W{1'b0}}, op_b[bus.mul_sel]};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*W-1:0] q0 [$];
  logic [2*W-1:0] q1 [$];
  bit gnt_log [$];
  bit ptr_m = 1'b0;
  bit prev_r0, prev_r1, prev_v0, prev_v1, seen1;
  int last_start = 0;
  bit hs0, hs1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input int unsigned a, input int unsigned b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Monitor: round-robin rule (sole requester wins, otherwise the one not served last).
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mul_start) begin
        check("grant", bus.mul_sel, (prev_r0 && prev_r1) ? ptr_m : prev_r1);
        last_start = cyc;
        gnt_log.push_back(bus.mul_sel);
      end
      if ((bus.rsp0_valid && !prev_v0) || (bus.rsp1_valid && !prev_v1))
        check("rsp_latency", cyc - last_start, MUL_LAT + 1);
      if (bus.rsp0_valid || bus.rsp1_valid)
        check("rsp_onehot", bus.rsp0_valid && bus.rsp1_valid, 0);
      if (bus.rsp1_valid) seen1 = 1'b1;
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
        else check("rsp0_data", bus.rsp_p, q0.pop_front());
        ptr_m = 1'b1;
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
        else check("rsp1_data", bus.rsp_p, q1.pop_front());
        ptr_m = 1'b0;
      end
    end
    prev_r0 = bus.req0_valid;
    prev_r1 = bus.req1_valid;
    prev_v0 = bus.rsp0_valid;
    prev_v1 = bus.rsp1_valid;
  end

  task automatic issue(input bit x, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[x] = a;
    op_b[x] = b;
    if (x) begin
      bus.req1_valid = 1'b1;
      q1.push_back(ref_prod(a, b));
    end else begin
      bus.req0_valid = 1'b1;
      q0.push_back(ref_prod(a, b));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hs0 = bus.rsp0_valid && bus.rsp0_ready;
    hs1 = bus.rsp1_valid && bus.rsp1_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bus.mul_start;
      1:       return bus.rsp0_valid;
      2:       return bus.rsp1_valid;
      default: return !bus.busy;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string name);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) check({"timeout_", name}, 0, 1);
  endtask

  task automatic finish_rsp(input bit x);
    wait_until(x ? 2 : 1, 60, x ? "rsp1" : "rsp0");
    @(posedge clk);
    #1;
    if (x) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int n, t0, hs_tot;
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset held 3 cycles with a pending request
    issue(0, 16'd7, 16'd9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_mul_sel", bus.mul_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp_p", bus.rsp_p, 0);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    n = 1;
    while (!bus.mul_start && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_after_reset", n, 2);
    finish_rsp(0);

    // Single request 3*5
    seen1 = 1'b0;
    t0 = cyc;
    issue(0, 16'd3, 16'd5);
    wait_until(0, 10, "t2_start");
    check("t2_start_lat", cyc - t0, 1);
    check("t2_sel", bus.mul_sel, 0);
    wait_until(1, 10, "t2_rsp");
    check("t2_rsp_lat", cyc - t0, 2 + MUL_LAT);
    check("t2_rsp_p", bus.rsp_p, 15);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    check("t2_no_rsp1", seen1, 0);

    // Back-pressure on requester 1 while requester 0 waits
    bus.rsp1_ready = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    issue(1, a, b);
    wait_until(2, 20, "t3_rsp1");
    issue(0, 16'd1234, 16'd4321);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_rsp1_valid_held", bus.rsp1_valid, 1);
      check("t3_rsp_p_held", bus.rsp_p, ref_prod(a, b));
      check("t3_no_start", bus.mul_start, 0);
    end
    @(posedge clk);
    #1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    check("t3_idle_after_hs", bus.busy, 0);
    finish_rsp(0);

    // Abort: requester 1 drops its request while the multiplier is running
    seen1 = 1'b0;
    issue(1, 16'd11, 16'd13);
    wait_until(0, 10, "t4_start");
    @(posedge clk);
    #1;
    check("t4_in_wait", bus.busy, 1);
    bus.req1_valid = 1'b0;
    q1.delete();
    ptr_m = 1'b0;
    @(posedge clk);
    #1;
    check("t4_abort_idle", bus.busy, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t4_no_rsp1", seen1, 0);
    issue(0, 16'd21, 16'd2);
    issue(1, 16'd100, 16'd300);
    wait_until(0, 10, "t4_contest");
    check("t4_next_grant", bus.mul_sel, 0);
    finish_rsp(0);
    finish_rsp(1);

    // Both requesting continuously from reset
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    q0.delete();
    q1.delete();
    ptr_m = 1'b0;
    issue(0, 16'($urandom), 16'($urandom));
    issue(1, 16'($urandom), 16'($urandom));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gnt_log.delete();
    n = 0;
    hs_tot = 0;
    while (hs_tot < 4 && n < 60) begin
      tick();
      n++;
      hs_tot += int'(hs0) + int'(hs1);
      if (hs0) begin
        if (hs_tot < 4) issue(0, 16'($urandom), 16'($urandom));
        else bus.req0_valid = 1'b0;
      end
      if (hs1) begin
        if (hs_tot < 4) issue(1, 16'($urandom), 16'($urandom));
        else bus.req1_valid = 1'b0;
      end
    end
    check("t5_cycles_for_4", n, 4 * (MUL_LAT + 3));
    check("t5_grants_logged", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) check("t5_grant_order", gnt_log[i], i % 2);
    end
    if (bus.req0_valid) finish_rsp(0);
    if (bus.req1_valid) finish_rsp(1);

    // Reset while a response is waiting
    bus.rsp0_ready = 1'b0;
    issue(0, 16'd77, 16'd88);
    wait_until(1, 20, "t6_rsp0");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rsp0_cleared", bus.rsp0_valid, 0);
    check("t6_busy_cleared", bus.busy, 0);
    bus.req0_valid = 1'b0;
    q0.delete();
    ptr_m = 1'b0;
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    issue(0, 16'd5, 16'd6);
    issue(1, 16'd7, 16'd8);
    wait_until(0, 10, "t6_contest");
    check("t6_grant_after_reset", bus.mul_sel, 0);
    finish_rsp(0);
    finish_rsp(1);

    // Random traffic with random back-pressure
    for (int c = 0; c < 800; c++) begin
      bus.rsp0_ready = ($urandom_range(0, 2) != 0);
      bus.rsp1_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (hs0) begin
        if ($urandom_range(0, 1) == 1) issue(0, 16'($urandom), 16'($urandom));
        else bus.req0_valid = 1'b0;
      end else if (!bus.req0_valid && $urandom_range(0, 3) == 0) begin
        issue(0, 16'($urandom), 16'($urandom));
      end
      if (hs1) begin
        if ($urandom_range(0, 1) == 1) issue(1, 16'($urandom), 16'($urandom));
        else bus.req1_valid = 1'b0;
      end else if (!bus.req1_valid && $urandom_range(0, 3) == 0) begin
        issue(1, 16'($urandom), 16'($urandom));
      end
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    n = 0;
    while ((bus.req0_valid || bus.req1_valid || bus.busy) && n < 200) begin
      tick();
      n++;
      if (hs0) bus.req0_valid = 1'b0;
      if (hs1) bus.req1_valid = 1'b0;
    end
    check("drain_done", n < 200, 1);
    check("sb_empty0", q0.size(), 0);
    check("sb_empty1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
